led_pulse_stretch: RTL and testbench
====================================

LED_PULSE_STRETCH -- requirements
Module: led_pulse_stretch

Interface
REQ-001 Parameter ON_N, default 8, SHALL set LED on-time to 2^ON_N clk cycles.
REQ-002 Parameter OFF_N, default 8, SHALL set the minimum LED off-gap to 2^OFF_N clk cycles.
REQ-003 Parameter PEND_W, default 2, SHALL set the width of the pending-event counter.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 evt  input  1  internal event, synchronous to clk; each rising edge counts as one event.
REQ-007 led  output  1  registered, human-visible pulse output.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 pend  output  PEND_W  queued events not yet shown.
REQ-010 ovf  output  1  sticky flag: an event was lost to pend saturation.

Function
REQ-011 Edge detect SHALL be rise = evt & ~evt_q, with evt_q registering evt every cycle.
REQ-012 The FSM SHALL have exactly three states: IDLE, ON, GAP.
REQ-013 IDLE + rise -> ON; led SHALL go high on the clk edge that samples rise, giving 1-cycle latency from the evt edge.
REQ-014 ON SHALL hold led=1 for exactly 2^ON_N cycles, then move to GAP.
REQ-015 GAP SHALL hold led=0 for exactly 2^OFF_N cycles.
REQ-016 At GAP end with pend>0, the block SHALL decrement pend and enter ON. At GAP end with pend=0, it SHALL enter IDLE.
REQ-017 The FSM SHALL use one shared cycle counter of width max(ON_N,OFF_N), cleared on every state entry.
REQ-018 busy SHALL be a registered state decode, aligned with led.
REQ-019 A rise in IDLE SHALL NOT alter pend.

Reset
REQ-020 While rst=1: state=IDLE, counter=0, evt_q=0, led=0, busy=0, pend=0, ovf=0, all effective on the next clk edge.
REQ-021 Reset asserted in ON or GAP SHALL abort the operation; led=0 and pend=0 the cycle after, with no residual pulse.
REQ-022 An evt edge present during the first cycle after rst deasserts SHALL be detected only if evt was 0 in the cycle rst was released.

Configuration
REQ-023 Macro LED_PEND_COUNT_EN defined:
  - a rise in ON or GAP SHALL increment pend, saturating at 2^PEND_W-1;
  - a rise while pend is saturated SHALL set ovf, which clears only on rst;
  - a rise coinciding with the GAP-end decrement SHALL leave pend unchanged, and the FSM SHALL enter ON.
REQ-024 Macro LED_PEND_COUNT_EN undefined:
  - a rise in ON SHALL restart the ON counter (retrigger, led stays 1);
  - a rise in GAP SHALL be ignored;
  - pend and ovf SHALL be constant 0.

Verification (ON_N=3 → 8 cycles; OFF_N=2 → 4 cycles; PEND_W=2)
REQ-025 Single 1-cycle evt pulse in IDLE -> led high for 8 cycles starting 1 cycle later, then low; busy high for 12 cycles; pend stays 0.
REQ-026 With macro defined, 3 evt edges during ON -> pend=3, then 4 pulses of 8 on / 4 off total; pend ends at 0; ovf=0.
REQ-027 With macro defined, 5 evt edges during ON -> pend saturates at 3 and ovf=1; exactly 4 pulses result.
REQ-028 With macro undefined, evt edge at ON cycle 6 -> led stays high 8 further cycles (14 total); an edge during GAP produces no pulse.
REQ-029 rst asserted at ON cycle 4 with pend=2 -> next cycle led=0, busy=0, pend=0; no further pulses.
REQ-030 evt held high 20 cycles -> exactly one event counted; a rise coinciding with the GAP-end decrement leaves pend unchanged and ON starts.

Source files
------------

// File: rtl/led_pulse_stretch.sv
// Stretches single-cycle internal events into human-visible LED pulses with a guaranteed off-gap.
// Define LED_PEND_COUNT_EN to queue events that arrive while busy; otherwise a rise during ON retriggers it.
module led_pulse_stretch #(
    parameter int ON_N   = 8,
    parameter int OFF_N  = 8,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              evt,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pend,
    output logic              ovf
);

    localparam int CW = (ON_N > OFF_N) ? ON_N : OFF_N;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [CW-1:0] ON_LAST  = CW'((64'd1 << ON_N) - 64'd1);
    localparam logic [CW-1:0] OFF_LAST = CW'((64'd1 << OFF_N) - 64'd1);

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          evt_q_reg;
    logic          hold_reg;
    logic          led_reg;
    logic          busy_reg;
    logic          rise;

    // hold_reg masks a level that was already high while reset was released,
    // so it is not mistaken for a fresh edge once evt_q restarts from 0.
    assign rise = evt & ~evt_q_reg & ~hold_reg;

`ifdef LED_PEND_COUNT_EN
    logic [PEND_W-1:0] pend_reg, pend_next;
    logic              ovf_reg, ovf_next;
    logic              pend_full;

    assign pend_full = (pend_reg == {PEND_W{1'b1}});
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
`ifdef LED_PEND_COUNT_EN
        pend_next  = pend_reg;
        ovf_next   = ovf_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (rise) begin
                    state_next = S_ON;
                end
            end
            S_ON: begin
`ifdef LED_PEND_COUNT_EN
                if (rise) begin
                    if (pend_full) ovf_next = 1'b1;
                    else           pend_next = pend_reg + 1'b1;
                end
                if (cnt_reg == ON_LAST) begin
                    state_next = S_GAP;
                    cnt_next   = '0;
                end
`else
                if (rise || cnt_reg == ON_LAST) begin
                    cnt_next = '0;
                end
                if (!rise && cnt_reg == ON_LAST) begin
                    state_next = S_GAP;
                end
`endif
            end
            S_GAP: begin
`ifdef LED_PEND_COUNT_EN
                if (cnt_reg == OFF_LAST) begin
                    cnt_next = '0;
                    // A rise at the gap end is consumed directly by the next ON.
                    if (rise) begin
                        state_next = S_ON;
                    end else if (pend_reg != '0) begin
                        state_next = S_ON;
                        pend_next  = pend_reg - 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else if (rise) begin
                    if (pend_full) ovf_next = 1'b1;
                    else           pend_next = pend_reg + 1'b1;
                end
`else
                if (cnt_reg == OFF_LAST) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end
`endif
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        hold_reg <= rst & evt;
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            evt_q_reg <= 1'b0;
            led_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            evt_q_reg <= evt;
            led_reg   <= (state_next == S_ON);
            busy_reg  <= (state_next != S_IDLE);
        end
    end

`ifdef LED_PEND_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            pend_reg <= pend_next;
            ovf_reg  <= ovf_next;
        end
    end

    assign pend = pend_reg;
    assign ovf  = ovf_reg;
`else
    assign pend = '0;
    assign ovf  = 1'b0;
`endif

    assign led  = led_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Directed bench for led_pulse_stretch (ON 8 cycles, GAP 4 cycles, 2-bit pend).
// Expectations follow LED_PEND_COUNT_EN when it is defined for the build.
module tb_led_pulse_stretch;

`ifdef LED_PEND_COUNT_EN
    localparam bit PC = 1'b1;
`else
    localparam bit PC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       evt = 1'b0;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    int led_cnt, busy_cnt, pulses, pend_max, ovf_seen;
    logic led_prev;

    led_pulse_stretch #(.ON_N(3), .OFF_N(2), .PEND_W(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .evt  (evt),
        .led  (led),
        .busy (busy),
        .pend (pend),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        led_cnt  = 0;
        busy_cnt = 0;
        pulses   = 0;
        pend_max = 0;
        ovf_seen = 0;
        led_prev = 1'b0;
    endtask

    // Drive evt for one cycle, accumulate the outputs of that cycle, then advance.
    task automatic cyc(input logic e, input int n = 1);
        for (int i = 0; i < n; i++) begin
            evt = e;
            led_cnt  += int'(led);
            busy_cnt += int'(busy);
            if (led && !led_prev) pulses++;
            led_prev = led;
            if (int'(pend) > pend_max) pend_max = int'(pend);
            if (ovf) ovf_seen = 1;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        evt = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_led", int'(led), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pend", int'(pend), 0);
        check("rst_ovf", int'(ovf), 0);

        // Single pulse: timing of ON and GAP edges
        clear_stats();
        cyc(1'b1);
        check("t1_latency_led", int'(led), 1);
        check("t1_latency_busy", int'(busy), 1);
        cyc(1'b0, 7);
        check("t1_on8_led", int'(led), 1);
        cyc(1'b0);
        check("t1_gap1_led", int'(led), 0);
        check("t1_gap1_busy", int'(busy), 1);
        cyc(1'b0, 3);
        check("t1_gap4_busy", int'(busy), 1);
        cyc(1'b0);
        check("t1_idle_busy", int'(busy), 0);
        cyc(1'b0, 10);
        check("t1_led_cycles", led_cnt, 8);
        check("t1_busy_cycles", busy_cnt, 12);
        check("t1_pulses", pulses, 1);
        check("t1_pend_max", pend_max, 0);

        // Three edges during ON
        do_reset();
        clear_stats();
        cyc(1'b1);
        cyc(1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1);
            cyc(1'b0);
        end
        check("t2_pend_after", int'(pend), PC ? 3 : 0);
        cyc(1'b0, 100);
        check("t2_pulses", pulses, PC ? 4 : 1);
        check("t2_led_cycles", led_cnt, PC ? 32 : 14);
        check("t2_busy_cycles", busy_cnt, PC ? 48 : 18);
        check("t2_pend_end", int'(pend), 0);
        check("t2_ovf", ovf_seen, 0);

        // Five edges: saturation and overflow
        do_reset();
        clear_stats();
        cyc(1'b1);
        cyc(1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1);
            cyc(1'b0);
        end
        check("t3_pend_sat", int'(pend), PC ? 3 : 0);
        check("t3_ovf_set", int'(ovf), PC ? 1 : 0);
        cyc(1'b0, 100);
        check("t3_pulses", pulses, PC ? 4 : 1);
        check("t3_led_cycles", led_cnt, PC ? 32 : 18);
        check("t3_busy_cycles", busy_cnt, PC ? 48 : 22);
        check("t3_ovf_sticky", int'(ovf), PC ? 1 : 0);
        do_reset();
        check("t3_ovf_cleared", int'(ovf), 0);

        // Edge at ON cycle 6, then an edge at GAP cycle 1 (retrigger build)
        clear_stats();
        cyc(1'b1);
        cyc(1'b0, 5);
        cyc(1'b1);
        cyc(1'b0, 8);
        cyc(1'b1);
        cyc(1'b0, 50);
        check("t5_pulses", pulses, PC ? 3 : 1);
        check("t5_led_cycles", led_cnt, PC ? 24 : 14);
        check("t5_busy_cycles", busy_cnt, PC ? 36 : 18);
        check("t5_pend_max", pend_max, PC ? 1 : 0);

        // Level held high counts once
        do_reset();
        clear_stats();
        cyc(1'b1, 20);
        cyc(1'b0, 30);
        check("t4_held_pulses", pulses, 1);
        check("t4_held_led", led_cnt, 8);
        check("t4_held_pend", pend_max, 0);

`ifdef LED_PEND_COUNT_EN
        // Rise coinciding with the GAP-end decrement
        do_reset();
        clear_stats();
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0, 9);
        check("t4_gapend_pre_pend", int'(pend), 1);
        cyc(1'b1);
        check("t4_gapend_led", int'(led), 1);
        check("t4_gapend_pend", int'(pend), 1);
        cyc(1'b0, 60);
        check("t4_gapend_pulses", pulses, 3);
        check("t4_gapend_pend_end", int'(pend), 0);
`endif

        // Reset in ON with queued events
        do_reset();
        clear_stats();
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b1);
        check("t6_pend_before", int'(pend), PC ? 2 : 0);
        rst = 1'b1;
        evt = 1'b0;
        tick();
        check("t6_led", int'(led), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_pend", int'(pend), 0);
        rst = 1'b0;
        clear_stats();
        cyc(1'b0, 40);
        check("t6_no_pulse", pulses, 0);
        check("t6_no_busy", busy_cnt, 0);

        // evt high across reset release is not an edge
        rst = 1'b1;
        evt = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_stats();
        cyc(1'b1, 10);
        check("t7_held_release", pulses, 0);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0, 20);
        check("t7_after_release", pulses, 1);

        // evt low at release, edge right after is detected
        rst = 1'b1;
        evt = 1'b0;
        tick();
        rst = 1'b0;
        cyc(1'b1);
        check("t7_first_cycle_edge", int'(led), 1);
        cyc(1'b0, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
